axis_sync_fifo: RTL and testbench
=================================

// Module: axis_sync_fifo
// PURPOSE
//  Single-clock AXI4-Stream FIFO sitting directly upstream of axis_width_converter in the USB3.0 datapath.
//  Buffers full AXIS beats (tdata/tstrb/tkeep/tlast/tid/tdest/tuser) and absorbs bursty USB endpoint traffic.
//  Presents a first-word-fall-through registered master port. Optional packet mode forwards only whole packets.
// PARAMETERS
//  TDATA_BYTES          8  tdata width in bytes (1-512); must equal downstream S_TDATA_WIDTH
//  TID_WIDTH            0  tid width in bits (0-32); 0 -> port is 1 bit, input ignored, output driven 0
//  TDEST_WIDTH          0  tdest width in bits (0-32); 0 handled as for TID_WIDTH
//  TUSER_WIDTH_PER_BYTE 0  tuser bits per data byte (0-2048); 0 handled as for TID_WIDTH
//  DEPTH_LOG2           5  RAM depth = 2**DEPTH_LOG2 entries (2-12)
//  PACKET_MODE          0  1 = hold output until a complete packet (tlast) is stored in RAM
// PORTS
//  aclk           in   1                   clock, all logic on rising edge
//  areset         in   1                   asynchronous, active-high reset
//  s_axis_tvalid  in   1                   slave beat valid
//  s_axis_tready  out  1                   slave ready = RAM not full
//  s_axis_tdata   in   TDATA_BYTES*8       slave data
//  s_axis_tstrb   in   TDATA_BYTES         slave byte strobe
//  s_axis_tkeep   in   TDATA_BYTES         slave byte keep
//  s_axis_tlast   in   1                   slave end of packet
//  s_axis_tid     in   max(TID_WIDTH,1)    slave stream id
//  s_axis_tdest   in   max(TDEST_WIDTH,1)  slave destination
//  s_axis_tuser   in   max(TDATA_BYTES*TUSER_WIDTH_PER_BYTE,1) slave sideband
//  m_axis_*       out/in                   mirror of s_axis_* (m_axis_tready is the only input)
//  occupancy      out  DEPTH_LOG2+2        beats held (RAM + output register), 0..2**DEPTH_LOG2+1
// BEHAVIOUR
//  - Reset (async assert, sync release): all pointers/counters 0, m_axis_tvalid=0, s_axis_tready=0,
//    occupancy=0; m_axis_t* data fields 0. s_axis_tready rises on first edge after release.
//    Reset mid-transfer discards all stored beats, including a partially stored packet.
//  - Storage: RAM of 2**DEPTH_LOG2 entries, one whole beat per entry; wr_ptr/rd_ptr DEPTH_LOG2+1 bits,
//    full = MSBs differ & LSBs equal, empty = ptrs equal; wrap-around by natural overflow.
//  - Write: beat stored when s_axis_tvalid & s_axis_tready; s_axis_tready = !full (registered, no comb path
//    from m_axis_tready). Simultaneous write and RAM read when full: ready stays 0 that cycle.
//  - Output register (one beat): loads from RAM when RAM non-empty, release allowed, and
//    (!m_axis_tvalid | m_axis_tready). Load and downstream accept in same cycle -> back-to-back, no bubble.
//  - Latency: beat accepted at edge k into empty FIFO -> m_axis_tvalid=1 after edge k+1 (PACKET_MODE=0).
//  - Throughput: 1 beat/cycle sustained both sides when neither side stalls.
//  - AXIS rules: m_axis_tvalid never drops and m_axis_t* never change while tvalid & !tready.
//  - Packet mode: pkt_cnt (DEPTH_LOG2+1 bits) = tlast beats in RAM; +1 on tlast write, -1 on tlast
//    load to output reg, unchanged if both. Release allowed iff pkt_cnt!=0 or RAM full (anti-deadlock
//    for packets longer than RAM; such packets then stream without store-and-forward).
//  - occupancy = RAM count + m_axis_tvalid, registered, updated every edge.
// STRUCTURE
//  - Shared package axis_pkg: clog2 function, AXIS width helpers (tuser width, max(w,1) port width).
//  - Sub-module axis_fifo_ram: simple dual-port RAM, sync write, async read, width = packed beat
//    {tuser,tdest,tid,tlast,tkeep,tstrb,tdata}; top-level holds pointers, pkt_cnt, output register.
// TESTING
//  - Reset, then 1 beat tdata=0x11, tlast=1 -> m_axis_tvalid after edge k+1, data 0x11, occupancy 1.
//  - DEPTH_LOG2=2, m_axis_tready=0, push 6 beats -> 5 accepted, s_axis_tready=0, occupancy=5;
//    release ready -> beats 0..4 out in order, no bubble.
//  - Both sides always ready, 1000 random beats -> one beat/cycle out, data/tkeep/tuser match scoreboard.
//  - PACKET_MODE=1, 3-beat packet with tlast held back 10 cycles -> m_axis_tvalid stays 0 until tlast
//    stored, then 3 consecutive beats; DEPTH_LOG2=2 with 8-beat packet -> RAM full releases, no deadlock.
//  - Assert areset mid-packet with occupancy=3 -> outputs 0 immediately, occupancy 0, next packet clean.
//  - Random m_axis_tready stalls -> m_axis_t* stable while tvalid & !tready (assertion checked).

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: width arithmetic for optional sideband fields
// and the packed-beat layout used by FIFO storage.
package axis_pkg;

    localparam int AXIS_MAX_ID_WIDTH   = 32;
    localparam int AXIS_MAX_DEST_WIDTH = 32;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Optional fields of zero width still need a 1-bit port.
    function automatic int port_width(input int width);
        return (width > 0) ? width : 1;
    endfunction

    function automatic int tuser_width(input int dataBytes, input int userPerByte);
        return dataBytes * userPerByte;
    endfunction

    function automatic int beat_width(
        input int dataBytes,
        input int idWidth,
        input int destWidth,
        input int userPerByte
    );
        return dataBytes * 8 + 2 * dataBytes + 1
             + port_width(idWidth)
             + port_width(destWidth)
             + port_width(tuser_width(dataBytes, userPerByte));
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read so the
// output register can load the head entry in the same cycle it is addressed.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
)(
    input  logic                      i_clk,
    input  logic                      i_wr_en,
    input  logic [clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic [clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [WIDTH-1:0]          o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with a first-word-fall-through registered master
// port and an optional packet mode that only releases whole stored packets.
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int TDATA_BYTES          = 8,
    parameter int TID_WIDTH            = 0,
    parameter int TDEST_WIDTH          = 0,
    parameter int TUSER_WIDTH_PER_BYTE = 0,
    parameter int DEPTH_LOG2           = 5,
    parameter int PACKET_MODE          = 0
)(
    input  logic                                                      aclk,
    input  logic                                                      areset,

    input  logic                                                      s_axis_tvalid,
    output logic                                                      s_axis_tready,
    input  logic [TDATA_BYTES*8-1:0]                                  s_axis_tdata,
    input  logic [TDATA_BYTES-1:0]                                    s_axis_tstrb,
    input  logic [TDATA_BYTES-1:0]                                    s_axis_tkeep,
    input  logic                                                      s_axis_tlast,
    input  logic [port_width(TID_WIDTH)-1:0]                          s_axis_tid,
    input  logic [port_width(TDEST_WIDTH)-1:0]                        s_axis_tdest,
    input  logic [port_width(tuser_width(TDATA_BYTES, TUSER_WIDTH_PER_BYTE))-1:0] s_axis_tuser,

    output logic                                                      m_axis_tvalid,
    input  logic                                                      m_axis_tready,
    output logic [TDATA_BYTES*8-1:0]                                  m_axis_tdata,
    output logic [TDATA_BYTES-1:0]                                    m_axis_tstrb,
    output logic [TDATA_BYTES-1:0]                                    m_axis_tkeep,
    output logic                                                      m_axis_tlast,
    output logic [port_width(TID_WIDTH)-1:0]                          m_axis_tid,
    output logic [port_width(TDEST_WIDTH)-1:0]                        m_axis_tdest,
    output logic [port_width(tuser_width(TDATA_BYTES, TUSER_WIDTH_PER_BYTE))-1:0] m_axis_tuser,

    output logic [DEPTH_LOG2+1:0]                                     occupancy
);

    localparam int DATA_W   = TDATA_BYTES * 8;
    localparam int ID_W     = port_width(TID_WIDTH);
    localparam int DEST_W   = port_width(TDEST_WIDTH);
    localparam int USER_W   = port_width(tuser_width(TDATA_BYTES, TUSER_WIDTH_PER_BYTE));
    localparam int BEAT_W   = beat_width(TDATA_BYTES, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH_PER_BYTE);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int PTR_W    = DEPTH_LOG2 + 1;
    localparam int OCC_W    = DEPTH_LOG2 + 2;

    localparam int STRB_LSB = DATA_W;
    localparam int KEEP_LSB = STRB_LSB + TDATA_BYTES;
    localparam int LAST_BIT = KEEP_LSB + TDATA_BYTES;
    localparam int ID_LSB   = LAST_BIT + 1;
    localparam int DEST_LSB = ID_LSB + ID_W;
    localparam int USER_LSB = DEST_LSB + DEST_W;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_pkt_cnt;
    logic              r_s_ready;
    logic              r_m_valid;
    logic [BEAT_W-1:0] r_m_beat;
    logic [OCC_W-1:0]  r_occupancy;

    logic [ID_W-1:0]   w_s_tid;
    logic [DEST_W-1:0] w_s_tdest;
    logic [USER_W-1:0] w_s_tuser;
    logic [BEAT_W-1:0] w_wr_beat;
    logic [BEAT_W-1:0] w_rd_beat;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_release;
    logic              w_load;
    logic              w_pkt_inc;
    logic              w_pkt_dec;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [PTR_W-1:0]  w_ram_count_next;
    logic [PTR_W-1:0]  w_pkt_cnt_next;
    logic              w_full_next;
    logic              w_m_valid_next;

    // Disabled sideband fields are stored as zero so the outputs read back 0.
    assign w_s_tid   = (TID_WIDTH > 0)            ? s_axis_tid   : '0;
    assign w_s_tdest = (TDEST_WIDTH > 0)          ? s_axis_tdest : '0;
    assign w_s_tuser = (TUSER_WIDTH_PER_BYTE > 0) ? s_axis_tuser : '0;

    assign w_wr_beat = {w_s_tuser, w_s_tdest, w_s_tid, s_axis_tlast,
                        s_axis_tkeep, s_axis_tstrb, s_axis_tdata};

    axis_fifo_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (aclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wr_data (w_wr_beat),
        .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_rd_beat)
    );

    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2])
                  && (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_wr_en = s_axis_tvalid && r_s_ready;

    // Releasing on full lets packets longer than the RAM stream through instead of deadlocking.
    assign w_release = (PACKET_MODE == 0) || (r_pkt_cnt != '0) || w_full;
    assign w_load    = !w_empty && w_release && (!r_m_valid || m_axis_tready);

    assign w_pkt_inc = w_wr_en && s_axis_tlast;
    assign w_pkt_dec = w_load && w_rd_beat[LAST_BIT];

    assign w_wr_ptr_next    = r_wr_ptr + PTR_W'(w_wr_en);
    assign w_rd_ptr_next    = r_rd_ptr + PTR_W'(w_load);
    assign w_ram_count_next = w_wr_ptr_next - w_rd_ptr_next;
    // Count can only reach DEPTH, so its top bit alone marks the full RAM.
    assign w_full_next      = w_ram_count_next[DEPTH_LOG2];
    assign w_m_valid_next   = w_load || (r_m_valid && !m_axis_tready);

    always_comb begin
        w_pkt_cnt_next = r_pkt_cnt;
        if (w_pkt_inc && !w_pkt_dec) begin
            w_pkt_cnt_next = r_pkt_cnt + PTR_W'(1);
        end else if (!w_pkt_inc && w_pkt_dec) begin
            w_pkt_cnt_next = r_pkt_cnt - PTR_W'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_cnt   <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_beat    <= '0;
            r_occupancy <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_pkt_cnt   <= w_pkt_cnt_next;
            r_s_ready   <= !w_full_next;
            r_m_valid   <= w_m_valid_next;
            r_occupancy <= OCC_W'(w_ram_count_next) + OCC_W'(w_m_valid_next);
            if (w_load) begin
                r_m_beat <= w_rd_beat;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_beat[DATA_W-1:0];
    assign m_axis_tstrb  = r_m_beat[STRB_LSB +: TDATA_BYTES];
    assign m_axis_tkeep  = r_m_beat[KEEP_LSB +: TDATA_BYTES];
    assign m_axis_tlast  = r_m_beat[LAST_BIT];
    assign m_axis_tid    = r_m_beat[ID_LSB +: ID_W];
    assign m_axis_tdest  = r_m_beat[DEST_LSB +: DEST_W];
    assign m_axis_tuser  = r_m_beat[USER_LSB +: USER_W];
    assign occupancy     = r_occupancy;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo: one streaming instance and one packet-mode
// instance, both small so full/anti-deadlock behaviour is reachable.
module tb_axis_sync_fifo;

    typedef struct packed {
        logic [3:0]  user;
        logic [1:0]  id;
        logic        last;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;

    int nChecks = 0;
    int nPass = 0;

    // Streaming instance (A) signals
    logic aSValid = 1'b0;
    logic aSReady;
    beat_t aSBeat = '0;
    logic aMValid;
    logic aMReady = 1'b0;
    logic [31:0] aMData;
    logic [3:0] aMStrb, aMKeep, aMUser;
    logic aMLast;
    logic [1:0] aMId;
    logic [0:0] aMDest;
    logic [3:0] aOcc;
    beat_t aMBeat;

    // Packet-mode instance (B) signals
    logic bSValid = 1'b0;
    logic bSReady;
    beat_t bSBeat = '0;
    logic bMValid;
    logic bMReady = 1'b0;
    logic [31:0] bMData;
    logic [3:0] bMStrb, bMKeep, bMUser;
    logic bMLast;
    logic [1:0] bMId;
    logic [0:0] bMDest;
    logic [3:0] bOcc;
    beat_t bMBeat;

    beat_t aExpQ[$];
    beat_t bExpQ[$];
    int aOutCount = 0;
    int bOutCount = 0;
    logic aHeld = 1'b0;
    logic bHeld = 1'b0;
    beat_t aHeldBeat = '0;
    beat_t bHeldBeat = '0;

    assign aMBeat = {aMUser, aMId, aMLast, aMKeep, aMStrb, aMData};
    assign bMBeat = {bMUser, bMId, bMLast, bMKeep, bMStrb, bMData};

    always #5 aclk = ~aclk;

    axis_sync_fifo #(
        .TDATA_BYTES(4), .TID_WIDTH(2), .TDEST_WIDTH(0), .TUSER_WIDTH_PER_BYTE(1),
        .DEPTH_LOG2(2), .PACKET_MODE(0)
    ) uA (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(aSValid), .s_axis_tready(aSReady),
        .s_axis_tdata(aSBeat.data), .s_axis_tstrb(aSBeat.strb), .s_axis_tkeep(aSBeat.keep),
        .s_axis_tlast(aSBeat.last), .s_axis_tid(aSBeat.id), .s_axis_tdest(1'b1),
        .s_axis_tuser(aSBeat.user),
        .m_axis_tvalid(aMValid), .m_axis_tready(aMReady),
        .m_axis_tdata(aMData), .m_axis_tstrb(aMStrb), .m_axis_tkeep(aMKeep),
        .m_axis_tlast(aMLast), .m_axis_tid(aMId), .m_axis_tdest(aMDest),
        .m_axis_tuser(aMUser), .occupancy(aOcc)
    );

    axis_sync_fifo #(
        .TDATA_BYTES(4), .TID_WIDTH(2), .TDEST_WIDTH(0), .TUSER_WIDTH_PER_BYTE(1),
        .DEPTH_LOG2(2), .PACKET_MODE(1)
    ) uB (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(bSValid), .s_axis_tready(bSReady),
        .s_axis_tdata(bSBeat.data), .s_axis_tstrb(bSBeat.strb), .s_axis_tkeep(bSBeat.keep),
        .s_axis_tlast(bSBeat.last), .s_axis_tid(bSBeat.id), .s_axis_tdest(1'b1),
        .s_axis_tuser(bSBeat.user),
        .m_axis_tvalid(bMValid), .m_axis_tready(bMReady),
        .m_axis_tdata(bMData), .m_axis_tstrb(bMStrb), .m_axis_tkeep(bMKeep),
        .m_axis_tlast(bMLast), .m_axis_tid(bMId), .m_axis_tdest(bMDest),
        .m_axis_tuser(bMUser), .occupancy(bOcc)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic beat_t randBeat(input logic lastBit);
        beat_t b;
        b.data = $urandom;
        b.strb = 4'($urandom_range(0, 15));
        b.keep = 4'($urandom_range(0, 15));
        b.last = lastBit;
        b.id   = 2'($urandom_range(0, 3));
        b.user = 4'($urandom_range(0, 15));
        return b;
    endfunction

    task automatic applyStimulusB(input beat_t b);
        int t;
        t = 0;
        bSValid = 1'b1;
        bSBeat  = b;
        while (!bSReady && t < 50) begin
            tick();
            t++;
        end
        checkOutput("B_sendTimeout", 64'(t < 50), 64'd1);
        tick();
        bSValid = 1'b0;
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle
    always @(negedge aclk) begin
        beat_t expBeat;
        if (areset) begin
            aHeld = 1'b0;
            bHeld = 1'b0;
        end else begin
            if (aSValid && aSReady) aExpQ.push_back(aSBeat);
            if (aMValid && aMReady) begin
                checkOutput("A_sbEmpty", 64'(aExpQ.size() != 0), 64'd1);
                if (aExpQ.size() != 0) begin
                    expBeat = aExpQ.pop_front();
                    checkOutput("A_beat", 64'(aMBeat), 64'(expBeat));
                end
                checkOutput("A_tdest", 64'(aMDest), 64'd0);
                aOutCount++;
            end
            if (aHeld) begin
                checkOutput("A_holdValid", 64'(aMValid), 64'd1);
                checkOutput("A_holdBeat", 64'(aMBeat), 64'(aHeldBeat));
            end
            aHeld     = aMValid && !aMReady;
            aHeldBeat = aMBeat;

            if (bSValid && bSReady) bExpQ.push_back(bSBeat);
            if (bMValid && bMReady) begin
                checkOutput("B_sbEmpty", 64'(bExpQ.size() != 0), 64'd1);
                if (bExpQ.size() != 0) begin
                    expBeat = bExpQ.pop_front();
                    checkOutput("B_beat", 64'(bMBeat), 64'(expBeat));
                end
                checkOutput("B_tdest", 64'(bMDest), 64'd0);
                bOutCount++;
            end
            if (bHeld) begin
                checkOutput("B_holdValid", 64'(bMValid), 64'd1);
                checkOutput("B_holdBeat", 64'(bMBeat), 64'(bHeldBeat));
            end
            bHeld     = bMValid && !bMReady;
            bHeldBeat = bMBeat;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        beat_t b;
        int nAcc;
        int outStart;
        int t;
        logic acc;

        // Reset state
        tick();
        tick();
        checkOutput("A_rstValid", 64'(aMValid), 64'd0);
        checkOutput("A_rstReady", 64'(aSReady), 64'd0);
        checkOutput("A_rstOcc", 64'(aOcc), 64'd0);
        checkOutput("A_rstBeat", 64'(aMBeat), 64'd0);
        checkOutput("B_rstValid", 64'(bMValid), 64'd0);
        checkOutput("B_rstReady", 64'(bSReady), 64'd0);
        checkOutput("B_rstOcc", 64'(bOcc), 64'd0);
        areset = 1'b0;
        #1;
        checkOutput("A_readyAtRelease", 64'(aSReady), 64'd0);
        tick();
        checkOutput("A_readyRise", 64'(aSReady), 64'd1);
        checkOutput("B_readyRise", 64'(bSReady), 64'd1);

        // Single beat latency
        b = randBeat(1'b1);
        b.data = 32'h11;
        aSBeat = b;
        aSValid = 1'b1;
        tick();
        aSValid = 1'b0;
        checkOutput("A_latValidK", 64'(aMValid), 64'd0);
        checkOutput("A_latOccK", 64'(aOcc), 64'd1);
        tick();
        checkOutput("A_latValidK1", 64'(aMValid), 64'd1);
        checkOutput("A_latData", 64'(aMData), 64'h11);
        checkOutput("A_latOccK1", 64'(aOcc), 64'd1);
        aMReady = 1'b1;
        tick();
        aMReady = 1'b0;
        checkOutput("A_latDrained", 64'(aMValid), 64'd0);

        // Fill to capacity with the output stalled
        b = randBeat(1'b0);
        b.data = 32'hA0;
        aSBeat = b;
        aSValid = 1'b1;
        nAcc = 0;
        for (int c = 0; c < 8; c++) begin
            acc = aSReady;
            tick();
            if (acc) begin
                nAcc++;
                if (nAcc < 6) begin
                    b = randBeat(1'b0);
                    b.data = 32'hA0 + 32'(nAcc);
                    aSBeat = b;
                end else begin
                    aSValid = 1'b0;
                end
            end
        end
        aSValid = 1'b0;
        checkOutput("A_fullAccepted", 64'(nAcc), 64'd5);
        checkOutput("A_fullReady", 64'(aSReady), 64'd0);
        checkOutput("A_fullOcc", 64'(aOcc), 64'd5);
        aMReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("A_drainNoBubble", 64'(aMValid), 64'd1);
            tick();
        end
        checkOutput("A_drainEmpty", 64'(aMValid), 64'd0);
        checkOutput("A_drainOcc", 64'(aOcc), 64'd0);

        // Sustained throughput, both sides ready
        outStart = aOutCount;
        nAcc = 0;
        aSValid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            aSBeat = randBeat(1'($urandom_range(0, 1)));
            acc = aSReady;
            tick();
            if (acc) nAcc++;
        end
        aSValid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("A_streamIn", 64'(nAcc), 64'd1000);
        checkOutput("A_streamOut", 64'(aOutCount - outStart), 64'd1000);
        checkOutput("A_streamQueue", 64'(aExpQ.size()), 64'd0);

        // Random stalls on both sides
        aSValid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            acc = aSValid && aSReady;
            tick();
            if (!aSValid || acc) begin
                aSValid = 1'($urandom_range(0, 1));
                aSBeat  = randBeat(1'($urandom_range(0, 1)));
            end
            aMReady = 1'($urandom_range(0, 1));
        end
        aSValid = 1'b0;
        aMReady = 1'b1;
        t = 0;
        while ((aExpQ.size() != 0 || aMValid) && t < 20) begin
            tick();
            t++;
        end
        checkOutput("A_stallDrain", 64'(aExpQ.size()), 64'd0);
        checkOutput("A_stallIdle", 64'(aMValid), 64'd0);

        // Packet mode: tlast held back
        bMReady = 1'b1;
        applyStimulusB(randBeat(1'b0));
        applyStimulusB(randBeat(1'b0));
        for (int c = 0; c < 10; c++) begin
            checkOutput("B_holdForLast", 64'(bMValid), 64'd0);
            tick();
        end
        bSBeat = randBeat(1'b1);
        bSValid = 1'b1;
        tick();
        bSValid = 1'b0;
        checkOutput("B_lastEdge", 64'(bMValid), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("B_pktBurst", 64'(bMValid), 64'd1);
            tick();
        end
        checkOutput("B_pktDone", 64'(bMValid), 64'd0);

        // Packet mode: packet longer than RAM
        outStart = bOutCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulusB(randBeat(1'(i == 7)));
        end
        t = 0;
        while ((bExpQ.size() != 0 || bMValid) && t < 30) begin
            tick();
            t++;
        end
        checkOutput("B_longOut", 64'(bOutCount - outStart), 64'd8);
        checkOutput("B_longQueue", 64'(bExpQ.size()), 64'd0);

        // Reset mid-packet
        bMReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulusB(randBeat(1'b0));
        end
        checkOutput("B_preRstOcc", 64'(bOcc), 64'd3);
        checkOutput("B_preRstValid", 64'(bMValid), 64'd0);
        #2;
        areset = 1'b1;
        #1;
        checkOutput("B_midRstValid", 64'(bMValid), 64'd0);
        checkOutput("B_midRstOcc", 64'(bOcc), 64'd0);
        checkOutput("B_midRstReady", 64'(bSReady), 64'd0);
        checkOutput("B_midRstBeat", 64'(bMBeat), 64'd0);
        checkOutput("A_midRstOcc", 64'(aOcc), 64'd0);
        aExpQ.delete();
        bExpQ.delete();
        tick();
        tick();
        areset = 1'b0;
        tick();
        checkOutput("B_postRstReady", 64'(bSReady), 64'd1);
        checkOutput("B_postRstOcc", 64'(bOcc), 64'd0);
        bMReady = 1'b1;
        outStart = bOutCount;
        applyStimulusB(randBeat(1'b0));
        applyStimulusB(randBeat(1'b1));
        t = 0;
        while ((bExpQ.size() != 0 || bMValid) && t < 20) begin
            tick();
            t++;
        end
        checkOutput("B_cleanOut", 64'(bOutCount - outStart), 64'd2);
        checkOutput("B_cleanQueue", 64'(bExpQ.size()), 64'd0);
        checkOutput("B_cleanOcc", 64'(bOcc), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
